// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM states, requester ids and
// default timing parameters.
package mem_arbiter_pkg;

    // Arbiter FSM states. IDLE picks a winner, ISSUE drives memory2c for
    // MEM_LAT cycles, DONE pulses the winner's ack.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    // Requester identifiers as stored in the latched winner id.
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    // Default number of cycles the memory enable is held before sampling.
    localparam int DEF_MEM_LAT    = 1;
    // Default limit on back-to-back data grants while a fetch is waiting.
    localparam int DEF_MAX_STREAK = 4;

endpackage

// File: rtl/arb_priority_pick.sv
// Combinational winner selection between fetch and data requesters.
// Data normally wins; fetch wins when the data streak has hit its limit
// while a fetch is waiting, so instruction fetch can never starve.
module arb_priority_pick
    import mem_arbiter_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic streak_full,
    output logic grant_valid,
    output logic grant_id
);

    // Any pending request produces a grant; the starvation rule flips priority.
    always_comb begin
        grant_valid = if_req || d_req;
        grant_id    = (d_req && !(if_req && streak_full)) ? REQ_D : REQ_IF;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory2c port between instruction fetch and data
// load/store.
//
// Handshake (both requesters): the requester raises req with addr/wr/wdata
// stable and holds it until ack. ack is a single-cycle pulse and the matching
// rdata is valid in that same cycle. The arbiter latches addr/wr/wdata at the
// grant, so later changes on those inputs do not affect the access in flight.
// A request withdrawn early is still completed and acknowledged.
//
// Timing: request seen in IDLE in cycle 0 -> memory driven in cycles
// 1..MEM_LAT -> ack in cycle MEM_LAT+1 -> IDLE again in MEM_LAT+2.
// Every output is registered; the asynchronous reset clears them at once,
// which aborts an in-flight access without ever acknowledging it.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int MAX_STREAK = DEF_MAX_STREAK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);

    // Latency counter only needs to reach MEM_LAT-1.
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    // Streak counter saturates at MAX_STREAK.
    localparam int STK_W = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_STREAK);

    arb_state_t state;
    arb_state_t next_state;

    // Access latched at grant time.
    logic              win_id;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_wr;
    logic [DATA_W-1:0] lat_wdata;
    logic [LAT_W-1:0]  lat_cnt;
    logic [STK_W-1:0]  streak;

    logic grant_valid;
    logic grant_id;
    logic streak_full;
    logic lat_last;
    logic grant_now;

    // Next-cycle values of the registered outputs.
    logic              if_ack_nxt;
    logic [DATA_W-1:0] if_rdata_nxt;
    logic              d_ack_nxt;
    logic [DATA_W-1:0] d_rdata_nxt;
    logic              mem_enable_nxt;
    logic              mem_wr_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_data_in_nxt;
    logic              busy_nxt;

    assign streak_full = (streak == STK_MAX);
    assign lat_last    = (lat_cnt == LAT_LAST);
    assign grant_now   = (state == IDLE) && grant_valid;

    arb_priority_pick u_pick (
        .if_req      (if_req),
        .d_req       (d_req),
        .streak_full (streak_full),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE -> ISSUE on any request, ISSUE -> DONE after
    // MEM_LAT cycles, DONE -> IDLE unconditionally.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (grant_valid) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (lat_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output logic: computes what each registered output holds next cycle.
    // The memory is driven during every ISSUE cycle; wr only in the first.
    always_comb begin
        if_ack_nxt      = 1'b0;
        d_ack_nxt       = 1'b0;
        if_rdata_nxt    = if_rdata;
        d_rdata_nxt     = d_rdata;
        mem_enable_nxt  = 1'b0;
        mem_wr_nxt      = 1'b0;
        mem_addr_nxt    = '0;
        mem_data_in_nxt = '0;
        busy_nxt        = (next_state != IDLE);
        unique case (state)
            IDLE: begin
                if (grant_valid) begin
                    mem_enable_nxt = 1'b1;
                    if (grant_id == REQ_D) begin
                        mem_wr_nxt      = d_wr;
                        mem_addr_nxt    = d_addr;
                        mem_data_in_nxt = d_wdata;
                    end else begin
                        mem_addr_nxt    = if_addr;
                    end
                end
            end
            ISSUE: begin
                if (lat_last) begin
                    // Final ISSUE cycle: sample memory, ack next cycle.
                    if (win_id == REQ_IF) begin
                        if_ack_nxt   = 1'b1;
                        if_rdata_nxt = mem_data_out;
                    end else begin
                        d_ack_nxt    = 1'b1;
                        d_rdata_nxt  = lat_wr ? '0 : mem_data_out;
                    end
                end else begin
                    mem_enable_nxt  = 1'b1;
                    mem_addr_nxt    = lat_addr;
                    mem_data_in_nxt = lat_wdata;
                end
            end
            DONE: begin
                // Ack cycle; memory already released.
            end
            default: begin
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_ack      <= 1'b0;
            if_rdata    <= '0;
            d_ack       <= 1'b0;
            d_rdata     <= '0;
            mem_enable  <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            busy        <= 1'b0;
        end else begin
            if_ack      <= if_ack_nxt;
            if_rdata    <= if_rdata_nxt;
            d_ack       <= d_ack_nxt;
            d_rdata     <= d_rdata_nxt;
            mem_enable  <= mem_enable_nxt;
            mem_wr      <= mem_wr_nxt;
            mem_addr    <= mem_addr_nxt;
            mem_data_in <= mem_data_in_nxt;
            busy        <= busy_nxt;
        end
    end

    // Latch the winning access at grant and count ISSUE cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_id    <= REQ_IF;
            lat_addr  <= '0;
            lat_wr    <= 1'b0;
            lat_wdata <= '0;
            lat_cnt   <= '0;
        end else if (grant_now) begin
            win_id  <= grant_id;
            lat_cnt <= '0;
            if (grant_id == REQ_D) begin
                lat_addr  <= d_addr;
                lat_wr    <= d_wr;
                lat_wdata <= d_wdata;
            end else begin
                lat_addr  <= if_addr;
                lat_wr    <= 1'b0;
                lat_wdata <= '0;
            end
        end else if (state == ISSUE) begin
            lat_cnt <= lat_cnt + LAT_W'(1);
        end
    end

    // Count data grants made while a fetch is waiting; any other grant clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (grant_now) begin
            if ((grant_id == REQ_D) && if_req) begin
                if (!streak_full) begin
                    streak <= streak + STK_W'(1);
                end
            end else begin
                streak <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LAT=1 checked through
// an ack scoreboard, one with MEM_LAT=3 checked cycle by cycle.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int EW = 1 + 16 + DW;

    localparam logic [DW-1:0] INSN_8   = 32'h00A0_0093;
    localparam logic [DW-1:0] STORE_W  = 32'hDEAD_BEEF;
    localparam logic [DW-1:0] WORD_40  = 32'h1234_5678;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   c0;

    logic [EW-1:0] exp_q[$];

    // MEM_LAT = 1 instance signals
    logic          if_req, if_ack, d_req, d_wr, d_ack;
    logic [AW-1:0] if_addr, d_addr, mem_addr;
    logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_data_in, mem_data_out;
    logic          mem_enable, mem_wr, busy;

    // MEM_LAT = 3 instance signals
    logic          if_req_3, if_ack_3, d_req_3, d_wr_3, d_ack_3;
    logic [AW-1:0] if_addr_3, d_addr_3, mem_addr_3;
    logic [DW-1:0] if_rdata_3, d_wdata_3, d_rdata_3, mem_data_in_3, mem_data_out_3;
    logic          mem_enable_3, mem_wr_3, busy_3;

    logic [DW-1:0] mem  [0:255];
    logic [DW-1:0] mem3 [0:255];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
    );

    mem_arbiter #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(if_req_3), .if_addr(if_addr_3), .if_ack(if_ack_3), .if_rdata(if_rdata_3),
        .d_req(d_req_3), .d_wr(d_wr_3), .d_addr(d_addr_3), .d_wdata(d_wdata_3),
        .d_ack(d_ack_3), .d_rdata(d_rdata_3),
        .mem_enable(mem_enable_3), .mem_wr(mem_wr_3), .mem_addr(mem_addr_3),
        .mem_data_in(mem_data_in_3), .mem_data_out(mem_data_out_3), .busy(busy_3)
    );

    // ---------------- memory models (async read, sync write) ----------------
    always @(posedge clk) begin
        if (rst) begin
            mem[8'h02] <= INSN_8;
        end else if (mem_enable && mem_wr) begin
            mem[8'(mem_addr >> 2)] <= mem_data_in;
        end
    end
    assign mem_data_out = (mem_enable && !mem_wr) ? mem[8'(mem_addr >> 2)] : '0;

    always @(posedge clk) begin
        if (rst) begin
            mem3[8'h10] <= WORD_40;
        end else if (mem_enable_3 && mem_wr_3) begin
            mem3[8'(mem_addr_3 >> 2)] <= mem_data_in_3;
        end
    end
    assign mem_data_out_3 = (mem_enable_3 && !mem_wr_3) ? mem3[8'(mem_addr_3 >> 2)] : '0;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ack(input logic id, input int c, input logic [DW-1:0] d);
        exp_q.push_back({id, 16'(c), d});
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_if_ack"},      64'(if_ack),      64'd0);
        check({tag, "_if_rdata"},    64'(if_rdata),    64'd0);
        check({tag, "_d_ack"},       64'(d_ack),       64'd0);
        check({tag, "_d_rdata"},     64'(d_rdata),     64'd0);
        check({tag, "_mem_enable"},  64'(mem_enable),  64'd0);
        check({tag, "_mem_wr"},      64'(mem_wr),      64'd0);
        check({tag, "_mem_addr"},    64'(mem_addr),    64'd0);
        check({tag, "_mem_data_in"}, 64'(mem_data_in), 64'd0);
        check({tag, "_busy"},        64'(busy),        64'd0);
        check({tag, "_busy3"},       64'(busy_3),      64'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic          act_id;
        logic [DW-1:0] act_data;
        if (!rst && (if_ack || d_ack)) begin
            check("ack_exclusive", 64'(if_ack && d_ack), 64'd0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ack: got if_ack=%b d_ack=%b at cycle %0d, expected no ack",
                         if_ack, d_ack, cyc);
            end else begin
                e        = exp_q.pop_front();
                act_id   = d_ack ? REQ_D : REQ_IF;
                act_data = d_ack ? d_rdata : if_rdata;
                check("ack_id",    64'(act_id),    64'(e[EW-1]));
                check("ack_cycle", 64'(cyc[15:0]), 64'(e[DW+15:DW]));
                check("ack_rdata", 64'(act_data),  64'(e[DW-1:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        if_req = 0; if_addr = '0; d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
        if_req_3 = 0; if_addr_3 = '0; d_req_3 = 0; d_wr_3 = 0; d_addr_3 = '0; d_wdata_3 = '0;

        // Reset for two cycles: everything quiet.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single fetch from 0x8.
        c0 = cyc;
        if_req = 1; if_addr = 32'h8;
        expect_ack(REQ_IF, c0 + 2, INSN_8);
        to_cycle(c0 + 1);
        check("fetch_mem_enable", 64'(mem_enable), 64'd1);
        check("fetch_mem_addr",   64'(mem_addr),   64'h8);
        check("fetch_mem_wr",     64'(mem_wr),     64'd0);
        check("fetch_busy",       64'(busy),       64'd1);
        to_cycle(c0 + 2);
        check("fetch_done_enable", 64'(mem_enable), 64'd0);
        check("fetch_done_wr",     64'(mem_wr),     64'd0);
        if_req = 0;
        to_cycle(c0 + 3);
        check("idle_busy", 64'(busy), 64'd0);

        // Store 0xDEADBEEF to 0x100.
        c0 = cyc;
        d_req = 1; d_wr = 1; d_addr = 32'h100; d_wdata = STORE_W;
        expect_ack(REQ_D, c0 + 2, '0);
        to_cycle(c0 + 1);
        check("store_mem_enable",  64'(mem_enable),  64'd1);
        check("store_mem_wr",      64'(mem_wr),      64'd1);
        check("store_mem_addr",    64'(mem_addr),    64'h100);
        check("store_mem_data_in", 64'(mem_data_in), 64'(STORE_W));
        to_cycle(c0 + 2);
        check("store_wr_one_cycle", 64'(mem_wr),   64'd0);
        check("store_if_rdata_hold", 64'(if_rdata), 64'(INSN_8));
        d_req = 0;
        to_cycle(c0 + 3);

        // Load back from 0x100.
        c0 = cyc;
        d_req = 1; d_wr = 0; d_wdata = '0;
        expect_ack(REQ_D, c0 + 2, STORE_W);
        to_cycle(c0 + 1);
        check("load_mem_wr", 64'(mem_wr), 64'd0);
        to_cycle(c0 + 2);
        d_req = 0;
        to_cycle(c0 + 3);

        // Simultaneous requests: data first, fetch in the next round.
        c0 = cyc;
        if_req = 1; if_addr = 32'h8;
        d_req = 1; d_wr = 0; d_addr = 32'h100;
        expect_ack(REQ_D,  c0 + 2, STORE_W);
        expect_ack(REQ_IF, c0 + 5, INSN_8);
        to_cycle(c0 + 2);
        d_req = 0;
        to_cycle(c0 + 5);
        if_req = 0;
        to_cycle(c0 + 6);

        // Starvation limit: four data grants, then the waiting fetch, then data again.
        c0 = cyc;
        if_req = 1; if_addr = 32'h8;
        d_req = 1; d_wr = 0; d_addr = 32'h100;
        for (int i = 0; i < 4; i++) expect_ack(REQ_D, c0 + 2 + 3 * i, STORE_W);
        expect_ack(REQ_IF, c0 + 14, INSN_8);
        expect_ack(REQ_D,  c0 + 17, STORE_W);
        to_cycle(c0 + 14);
        if_req = 0;
        to_cycle(c0 + 17);
        d_req = 0;
        to_cycle(c0 + 18);
        check("streak_cleared", 64'(dut.streak), 64'd0);
        check("starve_idle_busy", 64'(busy), 64'd0);

        // MEM_LAT = 3 instance: single load from 0x40, address changed after grant.
        c0 = cyc;
        d_req_3 = 1; d_wr_3 = 0; d_addr_3 = 32'h40;
        for (int k = 1; k <= 5; k++) begin
            to_cycle(c0 + k);
            check("lat3_mem_enable", 64'(mem_enable_3), 64'(k <= 3));
            check("lat3_busy",       64'(busy_3),       64'(k <= 4));
            check("lat3_d_ack",      64'(d_ack_3),      64'(k == 4));
            check("lat3_if_ack",     64'(if_ack_3),     64'd0);
            if (k <= 3) check("lat3_mem_addr", 64'(mem_addr_3), 64'h40);
            if (k == 1) d_addr_3 = 32'hFFFF_FFF0;
            if (k == 4) begin
                check("lat3_d_rdata", 64'(d_rdata_3), 64'(WORD_40));
                d_req_3 = 0;
            end
        end
        check("lat3_if_rdata", 64'(if_rdata_3), 64'd0);

        // Reset in the middle of a store: memory strobes drop at once, no ack.
        c0 = cyc;
        d_req = 1; d_wr = 1; d_addr = 32'h200; d_wdata = 32'h55AA_55AA;
        to_cycle(c0 + 1);
        check("abort_pre_enable", 64'(mem_enable), 64'd1);
        check("abort_pre_wr",     64'(mem_wr),     64'd1);
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        d_req = 0;
        rst = 1'b0;
        repeat (4) @(negedge clk);

        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory2c port between the instruction-fetch requester (PC path) and the data load/store requester.
- Each requester uses a req/ack handshake. The arbiter latches the winning request, drives the memory for MEM_LAT cycles, then returns read data with a one-cycle ack.
- Data accesses have priority over fetches. A streak limit prevents fetch starvation.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles the memory enable is held before mem_data_out is sampled; must be >= 1.
- MAX_STREAK, 4, maximum consecutive data grants while if_req is pending.

Ports:
- clk  input  1  clock; single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- if_req  input  1  fetch request; held until if_ack.
- if_addr  input  ADDR_W  fetch address; stable while if_req.
- if_ack  output  1  one-cycle pulse; if_rdata valid in the same cycle.
- if_rdata  output  DATA_W  fetched instruction word.
- d_req  input  1  data request; held until d_ack.
- d_wr  input  1  1 = store, 0 = load; stable while d_req.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_ack  output  1  one-cycle pulse.
- d_rdata  output  DATA_W  load data; 0 after a store.
- mem_enable  output  1  to memory2c enable.
- mem_wr  output  1  to memory2c wr.
- mem_addr  output  ADDR_W  to memory2c addr.
- mem_data_in  output  DATA_W  to memory2c data_in.
- mem_data_out  input  DATA_W  from memory2c data_out.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset:
  - state = IDLE, streak = 0.
  - All outputs 0, including rdata registers.
  - Reset mid-access aborts immediately: mem_enable and mem_wr drop asynchronously, and no ack is ever issued for the aborted request.
- States are IDLE, ISSUE and DONE; all outputs are registered.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise pick a winner:
    - data wins if d_req && !(if_req && streak == MAX_STREAK);
    - fetch wins otherwise.
  - Latch the winner's id, address, wr and wdata, then go to ISSUE with lat_cnt = 0.
- ISSUE:
  - mem_enable = 1 and mem_addr = latched address throughout.
  - mem_wr = 1 only in the first ISSUE cycle, and only for a store.
  - mem_data_in = latched wdata.
  - lat_cnt increments each cycle. At the edge where lat_cnt == MAX_LAT-1 (i.e. MEM_LAT cycles of ISSUE), capture mem_data_out into the winner's rdata register (0 for a store) and go to DONE.
- DONE:
  - The winner's ack = 1 for exactly this cycle; mem_enable = 0.
  - Go to IDLE unconditionally.
  - The requester drops req on the edge ending DONE, so the same request is never serviced twice.
- The non-winning requester's rdata holds its previous value and its ack stays 0.
- Latency: req first seen in IDLE at cycle 0 -> ack in cycle MEM_LAT+1. Back-to-back throughput is one access per MEM_LAT+2 cycles.
- Streak counter:
  - On a data grant while if_req = 1: streak = streak+1, saturating at MAX_STREAK.
  - On a fetch grant, or a data grant with if_req = 0: streak = 0.
- Simultaneous requests (streak < MAX_STREAK): data is served first and fetch waits in IDLE of the next round.
- Input changes to addr, wr or wdata after the grant are ignored, since values are latched at grant.
- A requester that deasserts req before ack violates the protocol; the arbiter still completes the access and pulses ack.
- Addresses pass through unmodified; no alignment check.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, ISSUE, DONE);
  - requester id constants (REQ_IF = 0, REQ_D = 1);
  - default MEM_LAT and MAX_STREAK.
- One natural sub-module: arb_priority_pick. It is combinational: inputs if_req, d_req, streak_full; outputs grant_valid and grant_id. It keeps the starvation rule isolated and unit-testable.
- The latency counter and streak counter stay inline.

Test Plan:
1. Reset then idle: rst = 1 for 2 cycles -> all outputs 0, busy = 0; assert rst again mid-ISSUE -> mem_enable drops in the same cycle and no ack follows.
2. Single fetch (MEM_LAT = 1):
   - Stimulus: if_req = 1, if_addr = 0x00000008, memory word at 0x8 = 0x00A00093.
   - Cycle 1: mem_enable = 1, mem_addr = 0x8.
   - Cycle 2: if_ack = 1, if_rdata = 0x00A00093.
   - mem_wr = 0 throughout.
3. Store then load:
   - Stimulus: d_req with d_wr = 1, d_addr = 0x100, d_wdata = 0xDEADBEEF.
   - Store: mem_wr = 1 for exactly one cycle and d_ack arrives 2 cycles after the grant, with d_rdata = 0.
   - A following load from 0x100 returns d_rdata = 0xDEADBEEF.
4. Simultaneous: if_req = d_req = 1 in the same IDLE cycle -> data is granted first (d_ack at cycle 2); fetch is granted next (if_ack at cycle 5); no cycle has both acks high.
5. Starvation (MAX_STREAK = 4): d_req re-asserted continuously with if_req held -> exactly 4 d_acks, then an if_ack, then data resumes; streak returns to 0.
6. MEM_LAT = 3: single load -> mem_enable high for 3 cycles, ack in cycle 4, busy high in cycles 1-4.
